// File: rtl/addsub_arbiter.sv
// Round-robin arbiter that shares one 4-bit sign/magnitude add/subtract datapath between NREQ requesters.
// Optional build macro ADDSUB_ARB_CNT_EN adds op_count/neg_count response counters.

module addsub (
    input  logic       m,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [4:0] yp
);

    // Add with carry out, or subtract returning sign/magnitude with no negative zero
    always_comb begin
        yp = 5'd0;
        if (!m) begin
            yp = {1'b0, a} + {1'b0, b};
        end else if (a >= b) begin
            yp = {1'b0, a - b};
        end else begin
            yp = {1'b1, b - a};
        end
    end

endmodule

module addsub_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ-1:0]   req_m,
    input  logic [4*NREQ-1:0] req_a,
    input  logic [4*NREQ-1:0] req_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [4:0]        rsp_y,
    output logic              busy
`ifdef ADDSUB_ARB_CNT_EN
    ,
    output logic [15:0]       op_count,
    output logic [15:0]       neg_count
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [NREQ-1:0] ONE_S   = NREQ'(1);
    localparam logic [IDW-1:0]  PTR_RST = IDW'(NREQ - 1);

    state_t          state_r;
    state_t          state_nx_s;
    logic            busy_r;
    logic [IDW-1:0]  ptr_r;
    logic [IDW-1:0]  id_r;
    logic            m_r;
    logic [3:0]      a_r;
    logic [3:0]      b_r;
    logic [IDW-1:0]  grant_id_s;
    logic            grant_found_s;
    logic            transfer_s;
    logic            hs_s;
    logic [4:0]      yp_s;
    logic            rsp_valid_r;
    logic [4:0]      rsp_y_r;
    logic [IDW-1:0]  rsp_id_r;
    int              idx_v;
    logic [NREQ-1:0] rot_v;

    addsub u_addsub (
        .m  (m_r),
        .a  (a_r),
        .b  (b_r),
        .yp (yp_s)
    );

    // First valid requester found searching upward from ptr+1 with wrap
    always_comb begin
        grant_found_s = 1'b0;
        grant_id_s    = '0;
        idx_v         = 0;
        rot_v         = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx_v         = int'(ptr_r) + k;
            idx_v         = (idx_v >= NREQ) ? (idx_v - NREQ) : idx_v;
            rot_v         = req_valid >> idx_v;
            grant_id_s    = (!grant_found_s && rot_v[0]) ? IDW'(idx_v) : grant_id_s;
            grant_found_s = grant_found_s | rot_v[0];
        end
    end

    assign transfer_s = (state_r == IDLE) && grant_found_s;
    assign hs_s       = rsp_valid_r && rsp_ready;

    // Ready is offered to the grantee only while idle and out of reset
    always_comb begin
        req_ready = '0;
        if ((state_r == IDLE) && !rst && grant_found_s) begin
            req_ready = ONE_S << grant_id_s;
        end else begin
            req_ready = '0;
        end
    end

    // Next-state decode
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE:    state_nx_s = transfer_s ? EXEC : IDLE;
            EXEC:    state_nx_s = RESP;
            RESP:    state_nx_s = hs_s ? IDLE : RESP;
            default: state_nx_s = IDLE;
        endcase
    end

    // State register with busy registered from the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            busy_r  <= (state_nx_s != IDLE);
        end
    end

    // Operand capture and pointer update at the transfer edge only
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_r <= PTR_RST;
            id_r  <= '0;
            m_r   <= 1'b0;
            a_r   <= 4'd0;
            b_r   <= 4'd0;
        end else if (transfer_s) begin
            ptr_r <= grant_id_s;
            id_r  <= grant_id_s;
            m_r   <= req_m[grant_id_s];
            a_r   <= req_a[{grant_id_s, 2'b00} +: 4];
            b_r   <= req_b[{grant_id_s, 2'b00} +: 4];
        end
    end

    // Response capture in EXEC, held through RESP until the consumer accepts
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_r <= 1'b0;
            rsp_y_r     <= 5'd0;
            rsp_id_r    <= '0;
        end else begin
            case (state_r)
                EXEC: begin
                    rsp_valid_r <= 1'b1;
                    rsp_y_r     <= yp_s;
                    rsp_id_r    <= id_r;
                end
                RESP: begin
                    if (hs_s) begin
                        rsp_valid_r <= 1'b0;
                    end
                end
                default: begin
                    rsp_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign rsp_valid = rsp_valid_r;
    assign rsp_y     = rsp_y_r;
    assign rsp_id    = rsp_id_r;
    assign busy      = busy_r;

`ifdef ADDSUB_ARB_CNT_EN
    logic [15:0] op_cnt_r;
    logic [15:0] neg_cnt_r;

    // Free-running wrap-around counters of accepted responses and negative results
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_cnt_r  <= 16'd0;
            neg_cnt_r <= 16'd0;
        end else if (hs_s) begin
            op_cnt_r  <= op_cnt_r + 16'd1;
            neg_cnt_r <= neg_cnt_r + {15'd0, rsp_y_r[4]};
        end
    end

    assign op_count  = op_cnt_r;
    assign neg_count = neg_cnt_r;
`endif

endmodule

// File: tb/tb_addsub_arbiter.sv
// Directed self-checking bench for addsub_arbiter: expected responses queued on accept, compared on handshake.
// Counter checks compile in only when ADDSUB_ARB_CNT_EN is defined.

module tb_addsub_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   req_m;
    logic [4*NREQ-1:0] req_a;
    logic [4*NREQ-1:0] req_b;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [4:0]        rsp_y;
    logic              busy;
`ifdef ADDSUB_ARB_CNT_EN
    logic [15:0]       op_count;
    logic [15:0]       neg_count;
`endif

    int         total = 0;
    int         bad   = 0;
    logic [6:0] sb[$];
    logic [6:0] exp_v;

    addsub_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_m     (req_m),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_y     (rsp_y),
        .busy      (busy)
`ifdef ADDSUB_ARB_CNT_EN
        ,
        .op_count  (op_count),
        .neg_count (neg_count)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] model(input logic m, input logic [3:0] a, input logic [3:0] b);
        if (!m) return {1'b0, a} + {1'b0, b};
        else if (a >= b) return {1'b0, a - b};
        else return {1'b1, b - a};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Raise valid for one requester, wait for its grant, queue the expected result, accept
    task automatic send(input int id, input logic m, input logic [3:0] a, input logic [3:0] b);
        int n;
        req_m[id]        = m;
        req_a[4*id +: 4] = a;
        req_b[4*id +: 4] = b;
        req_valid[id]    = 1'b1;
        #1;
        n = 0;
        while (!req_ready[id] && n < 20) begin
            tick();
            n++;
        end
        check("grant", 32'(req_ready), 32'(1 << id));
        sb.push_back({2'(id), model(m, a, b)});
        tick();
        req_valid[id] = 1'b0;
    endtask

    task automatic op(input int id, input logic m, input logic [3:0] a, input logic [3:0] b);
        send(id, m, a, b);
        tick();
        check("lat_valid", 32'(rsp_valid), 32'd1);
        tick();
        check("lat_done", 32'(rsp_valid), 32'd0);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 20) begin
            tick();
            n++;
        end
        check("idle", 32'(busy), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #3;
        rst = 1'b0;
    endtask

    // Response monitor: every accepted response must match the head of the scoreboard
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                check("rsp_unexpected", 32'(rsp_valid), 32'd0);
            end else begin
                exp_v = sb.pop_front();
                check("rsp_id", 32'(rsp_id), 32'(exp_v[6:5]));
                check("rsp_y", 32'(rsp_y), 32'(exp_v[4:0]));
            end
        end
    end

    initial begin
        int g;
        int cyc;
        int last;
        int gid;
        rst       = 1'b1;
        req_valid = '0;
        req_m     = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        req_valid = 4'hF;
        #1;
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_y", 32'(rsp_y), 32'd0);
        check("rst_rsp_id", 32'(rsp_id), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        req_valid = '0;
        rst       = 1'b0;
        rsp_ready = 1'b1;
        tick();

        // Single add with carry, latency N+2
        send(1, 1'b0, 4'd9, 4'd8);
        check("exec_busy", 32'(busy), 32'd1);
        check("exec_no_valid", 32'(rsp_valid), 32'd0);
        tick();
        check("single_valid", 32'(rsp_valid), 32'd1);
        check("single_id", 32'(rsp_id), 32'd1);
        check("single_y", 32'(rsp_y), 32'h11);
        tick();
        check("single_done", 32'(rsp_valid), 32'd0);
        check("single_idle", 32'(busy), 32'd0);

        op(0, 1'b1, 4'd3, 4'd7);
        op(0, 1'b1, 4'd7, 4'd3);
        op(0, 1'b1, 4'd5, 4'd5);

        // Round-robin with all requesters valid; operands change after each grant
        do_reset();
        tick();
        for (int i = 0; i < NREQ; i++) begin
            req_m[i]        = i[0];
            req_a[4*i +: 4] = 4'(3 * i + 2);
            req_b[4*i +: 4] = 4'(9 - 2 * i);
        end
        req_valid = 4'hF;
        #1;
        g = 0;
        cyc = 0;
        last = 0;
        while (g < 6 && cyc < 40) begin
            if (req_ready != '0) begin
                gid = g % NREQ;
                check("rr_grant", 32'(req_ready), 32'(1 << gid));
                if (g > 0) check("rr_spacing", 32'(cyc - last), 32'd3);
                sb.push_back({2'(gid), model(req_m[gid], req_a[4*gid +: 4], req_b[4*gid +: 4])});
                last = cyc;
                g++;
                tick();
                req_a[4*gid +: 4] = req_a[4*gid +: 4] + 4'd1;
            end else begin
                tick();
            end
            cyc++;
        end
        req_valid = '0;
        check("rr_count", 32'(g), 32'd6);
        wait_idle();

        // Backpressure: response held stable, no grants while stalled
        rsp_ready = 1'b0;
        send(2, 1'b0, 4'd15, 4'd15);
        req_valid = 4'b1011;
        tick();
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 32'(rsp_valid), 32'd1);
            check("bp_y", 32'(rsp_y), 32'h1E);
            check("bp_id", 32'(rsp_id), 32'd2);
            check("bp_busy", 32'(busy), 32'd1);
            check("bp_ready", 32'(req_ready), 32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        check("bp_regrant", 32'(req_ready), 32'h8);
        check("bp_idle", 32'(busy), 32'd0);
        sb.push_back({2'd3, model(req_m[3], req_a[15:12], req_b[15:12])});
        tick();
        req_valid = '0;
        wait_idle();

        // Async reset while in EXEC
        req_valid[3] = 1'b1;
        #1;
        check("ar_grant", 32'(req_ready), 32'h8);
        tick();
        #2;
        rst = 1'b1;
        #1;
        check("ar_rsp_valid", 32'(rsp_valid), 32'd0);
        check("ar_busy", 32'(busy), 32'd0);
        check("ar_req_ready", 32'(req_ready), 32'd0);
        rst = 1'b0;
        req_valid = 4'hF;
        #1;
        check("ar_first", 32'(req_ready), 32'h1);
        sb.push_back({2'd0, model(req_m[0], req_a[3:0], req_b[3:0])});
        tick();
        req_valid = '0;
        wait_idle();

        // Async reset while holding a response discards it
        rsp_ready = 1'b0;
        send(1, 1'b1, 4'd2, 4'd9);
        tick();
        check("rr_resp_held", 32'(rsp_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("rresp_valid", 32'(rsp_valid), 32'd0);
        check("rresp_busy", 32'(busy), 32'd0);
        void'(sb.pop_back());
        rst = 1'b0;
        rsp_ready = 1'b1;
        tick();
        check("rresp_none", 32'(rsp_valid), 32'd0);

`ifdef ADDSUB_ARB_CNT_EN
        do_reset();
        tick();
        check("cnt_rst", 32'(op_count), 32'd0);
        op(0, 1'b0, 4'd9, 4'd8);
        op(1, 1'b1, 4'd3, 4'd7);
        op(2, 1'b1, 4'd7, 4'd3);
        check("op_count", 32'(op_count), 32'd3);
        check("neg_count", 32'(neg_count), 32'd1);
`endif

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/addsub_arbiter.md
Name: addsub_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one 4-bit `addsub` datapath instance between NREQ requesters.
- Each requester submits an operation (M, A, B) over a valid/ready handshake.
- The block registers the winning operands, drives them into the shared `addsub`, captures the 5-bit sign/magnitude result and returns it with the requester ID.
- Sits between operand sources and downstream result consumers in the arithmetic section.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, width of rsp_id; must satisfy 2^IDW >= NREQ.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req_valid  input  NREQ  per-requester operation valid.
- req_ready  output  NREQ  per-requester accept; at most one bit high.
- req_m  input  NREQ  per-requester mode: 0 = add, 1 = subtract.
- req_a  input  4*NREQ  packed A operands; requester i uses bits [4i+3:4i].
- req_b  input  4*NREQ  packed B operands, same packing.
- rsp_valid  output  1  result valid.
- rsp_ready  input  1  consumer accepts result.
- rsp_id  output  IDW  index of the requester that owns rsp_y.
- rsp_y  output  5  result from `addsub`.
- busy  output  1  high in EXEC and RESP states.

Behaviour:
- Reset (async, rst=1): state=IDLE; rsp_valid=0; rsp_y=0; rsp_id=0; req_ready=0; busy=0; operand regs=0; rr pointer=NREQ-1, so requester 0 has first priority.
- FSM states:
  - IDLE:
    - req_ready is combinational. Only the grantee's bit is high; the grantee is the first i with req_valid[i]=1, searching from (ptr+1) mod NREQ upward with wrap.
    - On transfer (valid&ready): latch M/A/B/id into regs, set ptr=id, go to EXEC.
    - No valid inputs: stay in IDLE, all req_ready=0.
  - EXEC:
    - Registered operands drive the shared `addsub`.
    - Capture Yp into rsp_y and id into rsp_id; set rsp_valid=1; go to RESP.
    - req_ready=0.
  - RESP:
    - Hold rsp_valid, rsp_y and rsp_id stable until rsp_ready=1.
    - On handshake: rsp_valid=0 next cycle, go to IDLE.
    - req_ready=0.
- Latency: request accepted on cycle N gives rsp_valid=1 on cycle N+2. Minimum spacing between accepts is 3 cycles when rsp_ready is held high.
- Result rules, inherited from `addsub` (4-bit unsigned A, B):
  - M=0: rsp_y = A+B, 5-bit unsigned, carry in bit 4.
  - M=1, A>=B: rsp_y = {0, A-B}.
  - M=1, A<B: rsp_y = {1, B-A}, i.e. sign/magnitude.
  - A=B with M=1 gives 5'b00000 (no negative zero).
- Fairness: the pointer advances only on grant. A requester that drops valid before being granted loses nothing; there is no lock.
- A requester may drop or change req_valid/operands while not granted; the block samples only at the transfer edge.
- Simultaneous valids: exactly one is granted per IDLE cycle. Others wait at least 3 cycles.
- Pointer wrap: ptr=NREQ-1 wraps the search to index 0.
- Reset mid-operation (EXEC or RESP): the transaction is discarded, no response is produced, and all outputs take their reset values immediately.
- rsp_ready high while rsp_valid=0 has no effect.

Optional Feature:
- Macro: ADDSUB_ARB_CNT_EN.
- Defined:
  - Adds output op_count[15:0]. It increments by 1 on each response handshake (rsp_valid&rsp_ready) and wraps 16'hFFFF→0.
  - Reset value 0.
  - Also adds output neg_count[15:0], counting responses with rsp_y[4]=1, same wrap and reset rules.
- Undefined: both ports and their counters are absent. Arbitration and datapath behaviour are identical.

Test Plan:
- Single op: requester 1, M=0, A=9, B=8, rsp_ready=1 → req_ready[1]=1 at accept cycle N; at N+2 rsp_valid=1, rsp_id=1, rsp_y=5'b10001.
- Subtract both signs: requester 0, M=1, A=3, B=7 → rsp_y=5'b10100. Then M=1, A=7, B=3 → rsp_y=5'b00100. Then M=1, A=5, B=5 → rsp_y=5'b00000.
- Round-robin: all four requesters hold valid continuously, rsp_ready=1 → grant order is 0,1,2,3,0,1; accepts are spaced exactly 3 cycles apart.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid rises → rsp_y and rsp_id stay stable, busy=1, no req_ready asserted. Release → next grant occurs 1 cycle after the handshake.
- Async reset in EXEC: assert rst between clock edges → rsp_valid, busy and req_ready go to 0 without waiting for a clock edge. After release, requester 0 wins first.
- With ADDSUB_ARB_CNT_EN: 3 ops (9+8, 3−7, 7−3) → op_count=3, neg_count=1. Preload-style sweep of 65536 handshakes → op_count wraps to 0.
